// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : muldiv_pkg
//  Purpose : Shared definitions for the iterative RV32M multiply/divide unit:
//            func3 op encodings, one-hot FSM state encoding and a helper for
//            the step counter width.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    // func3 encodings of the M extension
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_MUL_RUN = 4'b0010,
        ST_DIV_RUN = 4'b0100,
        ST_DONE    = 4'b1000
    } state_e;

    // Step counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int step_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module  : muldiv_unit_if
//  Purpose : Request/response bundle between the core and muldiv_unit.
//  Signals : req_valid/req_ready/req_op/req_a/req_b  - request handshake
//            kill                                    - abort in-flight op
//            resp_valid/resp_ready/resp_result       - response handshake
//            busy_cnt                                - cycles spent running
//  Modports: master (core side), slave (unit side)
//  Rev     : 1.0  initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             kill;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic [CNT_W-1:0] busy_cnt;

    modport master (
        output req_valid, req_op, req_a, req_b, kill, resp_ready,
        input  req_ready, resp_valid, resp_result, busy_cnt
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, kill, resp_ready,
        output req_ready, resp_valid, resp_result, busy_cnt
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit_div_step.sv
`default_nettype none
// ============================================================================
//  Module  : div_step
//  Purpose : One restoring radix-2 division step (combinational): shift
//            {rem,quo} left by one, trial-subtract the divisor from the
//            partial remainder, keep or restore, and shift in the quotient bit.
//  Ports   : rem_i/quo_i - current partial remainder / quotient register
//            dvs_i       - divisor magnitude
//            rem_o/quo_o - values after this step
//  Rev     : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // rem < divisor always holds, so the shifted value fits in WIDTH+1 bits
    // and the top bit of the difference is a clean borrow flag.
    assign w_shift = {rem_i, quo_i[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, dvs_i};

    always_comb begin
        if (w_trial[WIDTH]) begin
            rem_o = w_shift[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o = w_trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module  : muldiv_unit
//  Purpose : Iterative RV32M multiply/divide unit. Shift-add multiplier
//            retiring MUL_BPC multiplier bits per cycle, restoring divider
//            retiring one quotient bit per cycle, 1-cycle divide special cases.
//  Ports   : clk  - clock, rising edge
//            rst  - asynchronous reset, active low
//            bus  - muldiv_unit_if.slave (request, kill, response, busy_cnt)
//  Rev     : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 1,
    parameter int CNT_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = step_cnt_width(WIDTH);
    localparam int NM = WIDTH / MUL_BPC;

    state_e               state_q,  state_d;
    logic [2:0]           op_q,     op_d;
    logic [CW-1:0]        cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;      // mul: product, div: {rem,quo}
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;    // mul: shifting multiplicand, div: divisor
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 sa_q, sa_d, sb_q, sb_d;
    logic [CNT_W-1:0]     busy_q,   busy_d;

    // ---------------- accept-time operand conditioning ----------------
    logic             w_a_signed, w_b_signed, w_sa, w_sb;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_special_res;
    logic             w_div_zero, w_div_ovf;

    assign w_a_signed = (bus.req_op == OP_MUL) || (bus.req_op == OP_MULH) ||
                        (bus.req_op == OP_MULHSU) || (bus.req_op == OP_DIV) ||
                        (bus.req_op == OP_REM);
    assign w_b_signed = (bus.req_op == OP_MUL) || (bus.req_op == OP_MULH) ||
                        (bus.req_op == OP_DIV) || (bus.req_op == OP_REM);
    assign w_sa       = w_a_signed & bus.req_a[WIDTH-1];
    assign w_sb       = w_b_signed & bus.req_b[WIDTH-1];
    assign w_mag_a    = w_sa ? -bus.req_a : bus.req_a;
    assign w_mag_b    = w_sb ? -bus.req_b : bus.req_b;

    assign w_div_zero = (bus.req_b == '0);
    assign w_div_ovf  = w_b_signed && (bus.req_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.req_b);
    // Divide-by-zero takes precedence; the raw dividend is the remainder.
    assign w_special_res = bus.req_op[1] ? (w_div_zero ? bus.req_a : '0)
                                         : (w_div_zero ? '1 : {1'b1, {(WIDTH-1){1'b0}}});

    // ---------------- per-cycle datapath ----------------
    logic [2*WIDTH-1:0] w_prod, w_prod_fin;
    logic [WIDTH-1:0]   w_mul_res, w_div_res, w_rem_step, w_quo_step;
    logic [CW-1:0]      w_cnt_dec;
    logic               w_last;

    always_comb begin
        w_prod = acc_q;
        for (int j = 0; j < MUL_BPC; j++) begin
            if (mplier_q[j]) begin
                w_prod = w_prod + (mcand_q << j);
            end
        end
    end

    assign w_prod_fin = (sa_q ^ sb_q) ? -w_prod : w_prod;
    assign w_mul_res  = (op_q == OP_MUL) ? w_prod_fin[WIDTH-1:0] : w_prod_fin[2*WIDTH-1:WIDTH];

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i (acc_q[2*WIDTH-1:WIDTH]),
        .quo_i (acc_q[WIDTH-1:0]),
        .dvs_i (mcand_q[WIDTH-1:0]),
        .rem_o (w_rem_step),
        .quo_o (w_quo_step)
    );

    // Remainder takes the dividend's sign, quotient the xor of both signs.
    assign w_div_res = op_q[1] ? (sa_q ? -w_rem_step : w_rem_step)
                               : ((sa_q ^ sb_q) ? -w_quo_step : w_quo_step);

    assign w_cnt_dec = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    assign w_last    = (cnt_q == CW'(1));

    // ---------------- next state ----------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        busy_d   = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && !bus.kill) begin
                    op_d = bus.req_op;
                    sa_d = w_sa;
                    sb_d = w_sb;
                    if (!bus.req_op[2]) begin
                        state_d  = ST_MUL_RUN;
                        cnt_d    = CW'(NM);
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, w_mag_a};
                        mplier_d = w_mag_b;
                    end else if (w_div_zero || w_div_ovf) begin
                        state_d  = ST_DONE;
                        result_d = w_special_res;
                    end else begin
                        state_d  = ST_DIV_RUN;
                        cnt_d    = CW'(WIDTH);
                        acc_d    = {{WIDTH{1'b0}}, w_mag_a};
                        mcand_d  = {{WIDTH{1'b0}}, w_mag_b};
                    end
                end
            end
            ST_MUL_RUN: begin
                busy_d = busy_q + CNT_W'(1);
                if (bus.kill) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = w_prod;
                    mcand_d  = mcand_q << MUL_BPC;
                    mplier_d = mplier_q >> MUL_BPC;
                    cnt_d    = w_cnt_dec;
                    if (w_last) begin
                        state_d  = ST_DONE;
                        result_d = w_mul_res;
                    end
                end
            end
            ST_DIV_RUN: begin
                busy_d = busy_q + CNT_W'(1);
                if (bus.kill) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = {w_rem_step, w_quo_step};
                    cnt_d = w_cnt_dec;
                    if (w_last) begin
                        state_d  = ST_DONE;
                        result_d = w_div_res;
                    end
                end
            end
            ST_DONE: begin
                if (bus.kill || bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.resp_valid  = (state_q == ST_DONE);
    assign bus.resp_result = result_q;
    assign bus.busy_cnt    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_muldiv_unit
//  Purpose : Self-checking bench for muldiv_unit: table of directed vectors
//            with hand-computed results and latencies, plus sequences for
//            response back-pressure, kill, kill-vs-accept, async reset and
//            the MUL_BPC=4 variant.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W), .CNT_W(32)) bus  ();
    muldiv_unit_if #(.WIDTH(W), .CNT_W(32)) bus4 ();

    muldiv_unit #(.WIDTH(W), .MUL_BPC(1), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    muldiv_unit #(.WIDTH(W), .MUL_BPC(4), .CNT_W(32)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_busy = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;   // edges after the accepting edge until resp_valid is seen
        int          hold;  // cycles to hold resp_ready low in DONE
    } vec_t;

    vec_t vecs [21];
    vec_t vecs4 [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v, input string name);
        int lat;
        bus.req_op    = v.op;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.req_valid = 1'b1;
        tick;
        // Scramble inputs after accept; the unit must use the latched copies.
        bus.req_valid = 1'b0;
        bus.req_op    = ~v.op;
        bus.req_a     = ~v.a;
        bus.req_b     = ~v.b;
        lat = 0;
        while (!bus.resp_valid && lat < 100) begin
            tick;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(v.lat));
        check({name, " result"}, 64'(bus.resp_result), 64'(v.res));
        check({name, " req_ready in DONE"}, 64'(bus.req_ready), 64'd0);
        for (int i = 0; i < v.hold; i++) begin
            tick;
            check({name, " held result"}, 64'(bus.resp_result), 64'(v.res));
            check({name, " held valid"}, 64'(bus.resp_valid), 64'd1);
        end
        bus.resp_ready = 1'b1;
        tick;
        bus.resp_ready = 1'b0;
        check({name, " back to idle"}, {62'd0, bus.req_ready, bus.resp_valid}, 64'b10);
        exp_busy += 32'(v.lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32, 0};
        vecs[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 32, 0};
        vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, 0};
        vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32, 0};
        vecs[4]  = '{OP_MUL,    32'h12345678, 32'h10,       32'h23456780, 32, 0};
        vecs[5]  = '{OP_MULHU,  32'h12345678, 32'h10,       32'h00000001, 32, 0};
        vecs[6]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32, 0};
        vecs[7]  = '{OP_MULHSU, 32'd2,        32'hFFFFFFFF, 32'h00000001, 32, 0};
        vecs[8]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32, 0};
        vecs[9]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32, 0};
        vecs[10] = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       32, 5};
        vecs[11] = '{OP_REMU,   32'd100,      32'd7,        32'd2,        32, 0};
        vecs[12] = '{OP_DIVU,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32, 0};
        vecs[13] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        32, 0};
        vecs[14] = '{OP_DIV,    32'h80000000, 32'd2,        32'hC0000000, 32, 0};
        // Special cases: result already valid in the cycle after the accepting edge.
        vecs[15] = '{OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 0,  0};
        vecs[16] = '{OP_REM,    32'd5,        32'd0,        32'd5,        0,  0};
        vecs[17] = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 0,  0};
        vecs[18] = '{OP_REMU,   32'd5,        32'd0,        32'd5,        0,  0};
        vecs[19] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0,  0};
        vecs[20] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        0,  0};

        vecs4[0] = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 8,  0};
        vecs4[1] = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8,  0};

        bus.req_valid  = 1'b0; bus.req_op  = '0; bus.req_a  = '0; bus.req_b  = '0;
        bus.kill       = 1'b0; bus.resp_ready  = 1'b0;
        bus4.req_valid = 1'b0; bus4.req_op = '0; bus4.req_a = '0; bus4.req_b = '0;
        bus4.kill      = 1'b0; bus4.resp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready",   64'(bus.req_ready),   64'd1);
        check("reset resp_valid",  64'(bus.resp_valid),  64'd0);
        check("reset resp_result", 64'(bus.resp_result), 64'd0);
        check("reset busy_cnt",    64'(bus.busy_cnt),    64'd0);
        rst = 1'b1;
        tick;

        // Directed vectors
        for (int i = 0; i < 21; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end
        check("busy_cnt after table", 64'(bus.busy_cnt), 64'(exp_busy));

        // Kill during the 10th MUL_RUN cycle
        bus.req_op = OP_MUL; bus.req_a = 32'd3; bus.req_b = 32'd5; bus.req_valid = 1'b1;
        tick;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        bus.kill = 1'b1;
        tick;
        bus.kill = 1'b0;
        exp_busy += 32'd10;
        check("kill idle req_ready", 64'(bus.req_ready),  64'd1);
        check("kill no resp_valid",  64'(bus.resp_valid), 64'd0);
        check("kill busy_cnt",       64'(bus.busy_cnt),   64'(exp_busy));
        repeat (3) tick;
        check("kill no late resp",   64'(bus.resp_valid), 64'd0);

        // kill together with req_valid in IDLE: no accept
        bus.req_op = OP_DIVU; bus.req_a = 32'd9; bus.req_b = 32'd3;
        bus.req_valid = 1'b1; bus.kill = 1'b1;
        tick;
        bus.req_valid = 1'b0; bus.kill = 1'b0;
        check("kill beats accept", 64'(bus.req_ready), 64'd1);
        tick;
        check("kill beats accept busy", 64'(bus.busy_cnt), 64'(exp_busy));

        // Asynchronous reset in the middle of a divide
        bus.req_op = OP_DIV; bus.req_a = 32'hFFFFFFF9; bus.req_b = 32'd2; bus.req_valid = 1'b1;
        tick;
        bus.req_valid = 1'b0;
        repeat (5) tick;
        check("mid-div busy_cnt", 64'(bus.busy_cnt), 64'(exp_busy + 32'd5));
        #2;
        rst = 1'b0;
        #1;
        check("async rst req_ready",   64'(bus.req_ready),   64'd1);
        check("async rst resp_valid",  64'(bus.resp_valid),  64'd0);
        check("async rst resp_result", 64'(bus.resp_result), 64'd0);
        check("async rst busy_cnt",    64'(bus.busy_cnt),    64'd0);
        tick;
        rst = 1'b1;
        exp_busy = '0;
        tick;
        run_op(vecs[10], "post-reset divu");
        check("post-reset busy_cnt", 64'(bus.busy_cnt), 64'(exp_busy));

        // MUL_BPC=4 instance
        for (int i = 0; i < 2; i++) begin
            bus4.req_op = vecs4[i].op; bus4.req_a = vecs4[i].a; bus4.req_b = vecs4[i].b;
            bus4.req_valid = 1'b1;
            tick;
            bus4.req_valid = 1'b0;
            lat = 0;
            while (!bus4.resp_valid && lat < 100) begin
                tick;
                lat++;
            end
            check($sformatf("bpc4 vec%0d latency", i), 64'(lat), 64'(vecs4[i].lat));
            check($sformatf("bpc4 vec%0d result", i), 64'(bus4.resp_result), 64'(vecs4[i].res));
            bus4.resp_ready = 1'b1;
            tick;
            bus4.resp_ready = 1'b0;
        end
        check("bpc4 busy_cnt", 64'(bus4.busy_cnt), 64'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
